ring_token_arbiter: RTL and testbench
=====================================

Name: ring_token_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters using a rotating one-hot priority token. The token rotates right (MSB toward LSB, LSB wraps to MSB), the same rotation as the team's ring counters. A grant is held while the owner keeps its request asserted, up to a burst limit, after which it is forcibly revoked. The block sits between requesting engines and a shared datapath or bus, and drives that resource's select lines.

Parameters:
N, 4, number of requesters; width of req, grant and ptr (N >= 1).
CNT_W, 3, burst counter width; burst limit MAX_BURST = 2**CNT_W cycles (8 by default).

Ports:
clk  input  1  clock; all state updates on posedge.
init  input  1  synchronous, active-high reset; sampled on posedge clk.
req  input  N  request level per requester; bit i belongs to requester i.
grant  output  N  registered one-hot grant, or all-zero when no grant.
busy  output  1  high while any grant bit is high (state OWN).
ptr  output  N  registered one-hot priority token: the highest-priority requester for the next arbitration.
expire  output  1  single-cycle pulse, registered, on a forced burst-limit release.

Behaviour:
- Reset (init=1 at posedge, overrides all else, including mid-grant):
  - grant=0, busy=0, expire=0, burst counter=0, state=IDLE.
  - ptr = one-hot with only bit N-1 set (4'b1000 for N=4).
- States: IDLE, OWN. busy=1 exactly in OWN. grant is nonzero exactly in OWN.
- Priority order: starting at the ptr bit, then each successive right rotation (bit N-1, N-2, ..., 0, N-1, ...). The first requester in that order with req high wins.
- IDLE:
  - If req=0, stay in IDLE; all outputs hold.
  - If req!=0, at the next posedge set grant to the winner's one-hot, set counter=1, and go to OWN.
  - Latency from req sampled high to grant high: 1 cycle.
- OWN, evaluated each posedge with owner o = grant bit:
  - Voluntary release: req[o]=0. Next cycle grant=0, ptr = rotate-right(grant), state=IDLE, expire stays 0.
  - Forced release: req[o]=1 and counter==MAX_BURST. Next cycle grant=0, ptr = rotate-right(grant), expire=1 for exactly that cycle, state=IDLE.
  - Otherwise: grant holds and counter increments.
  - Voluntary release takes precedence when both conditions hold (req[o]=0 at limit gives expire=0).
- Release always inserts one idle cycle (grant=0) before the next grant. The next grant follows the IDLE rules using the updated ptr.
- ptr changes only on a release or on init. It stays one-hot at all times.
- Requests from non-owners during OWN are ignored until the release cycle. A non-owner request pulse that falls before the IDLE cycle is lost.
- grant is never given to a requester whose req bit was 0 at the arbitration edge.
- Counter never exceeds MAX_BURST. It is not observable except through expire timing.
- N=1: rotate-right is the identity, so ptr stays 1'b1 and arbitration degenerates to a burst-limited grant.
- expire is 0 in every cycle other than the one following a forced release.

Test Plan:
- Reset, N=4: hold init=1 for 2 cycles with req=4'b1111 -> grant=0000, busy=0, expire=0, ptr=1000 throughout. Repeat from a random nonzero state and check the same values.
- Single grant and burst limit: after init, hold req=0011 -> grant=0010 one cycle after req is sampled, held for 8 cycles. Then one cycle with grant=0000, expire=1, ptr=0001. The next cycle gives grant=0001.
- Round-robin fairness: after init, each requester drops req one cycle after receiving its grant, then re-raises it; req otherwise =1111 -> grant sequence 1000, 0100, 0010, 0001, 1000 with one idle cycle between grants, and expire never set.
- Voluntary release: req=0100 only, requester drops req after its grant has been high for 3 cycles -> grant=0100 for exactly 3 cycles, then 0000 with expire=0 and ptr=0010.
- Release at limit: owner drops req in the same cycle the counter reaches 8 -> release with expire=0, ptr rotated.
- Mid-grant reset and ignored pulse: while grant=0010, pulse req[3] for one cycle, then assert init -> grant never 1000 during the pulse. After init, next edge gives grant=0000, ptr=1000, busy=0. The following arbitration uses ptr=1000.

Source files
------------

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token and a burst-limited grant.
// Grant appears 1 cycle after a request is sampled; every release inserts one idle cycle.
module ring_token_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         init,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] ptr,
    output logic         expire
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam int             MAX_BURST = 1 << CNT_W;
    localparam logic [CNT_W:0] CNT_MAX   = MAX_BURST[CNT_W:0];
    localparam logic [N-1:0]   PTR_RST   = N'(1) << (N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [CNT_W:0] cnt_q, cnt_d;
    logic           expire_q, expire_d;

    logic [N-1:0]   win;
    logic [N-1:0]   mask;
    logic           found;

    // MSB toward LSB with LSB wrapping to MSB; identity when N == 1.
    function automatic logic [N-1:0] rotr(input logic [N-1:0] v);
        return (v >> 1) | (v << (N - 1));
    endfunction

    always_ff @(posedge clk) begin
        if (init) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= PTR_RST;
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    // Walk the priority order starting at the token; first live request wins.
    always_comb begin
        win   = '0;
        mask  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && ((req & mask) != '0)) begin
                win   = mask;
                found = 1'b1;
            end
            mask = rotr(mask);
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = OWN;
                    grant_d = win;
                    cnt_d   = (CNT_W + 1)'(1);
                end
            end
            OWN: begin
                // A dropped request wins over the limit, so no expire in that case.
                if ((req & grant_q) == '0 || cnt_q == CNT_MAX) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    ptr_d    = rotr(grant_q);
                    cnt_d    = '0;
                    expire_d = ((req & grant_q) != '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        grant  = grant_q;
        ptr    = ptr_q;
        expire = expire_q;
        busy   = (state_q == OWN);
    end

endmodule

// File: tb/tb_ring_token_arbiter.sv
module tb_ring_token_arbiter;

    localparam int N = 4;
    localparam int CNT_W = 3;
    localparam int MAXB = 1 << CNT_W;

    logic         clk;
    logic         init;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         busy;
    logic [N-1:0] ptr;
    logic         expire;

    int total = 0;
    int bad = 0;

    ring_token_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .init(init), .req(req),
        .grant(grant), .busy(busy), .ptr(ptr), .expire(expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         i;
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic         b;
        logic [N-1:0] p;
        logic         e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic i, input logic [N-1:0] r, input logic [N-1:0] g,
                       input logic b, input logic [N-1:0] p, input logic e);
        vec_t v;
        v.i = i; v.r = r; v.g = g; v.b = b; v.p = p; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic i, input logic [N-1:0] r);
        init = i;
        req  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [N-1:0] g,
                         input logic b, input logic [N-1:0] p, input logic e);
        total++;
        if (grant !== g || busy !== b || ptr !== p || expire !== e) begin
            bad++;
            $display("FAIL %s #%0d: got grant=%b busy=%b ptr=%b expire=%b, want grant=%b busy=%b ptr=%b expire=%b",
                     name, idx, grant, busy, ptr, expire, g, b, p, e);
        end
    endtask

    // Reference model: owner index (-1 when idle), token index, burst count.
    int       m_owner, m_pidx, m_cnt;
    logic     m_exp;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input logic i, input logic [N-1:0] r);
        int idx;
        m_exp = 1'b0;
        if (i) begin
            m_owner = -1; m_pidx = N - 1; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_pidx - k + N) % N;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_cnt = 1;
                end
            end
        end else if (!r[m_owner] || m_cnt == MAXB) begin
            m_exp   = r[m_owner];
            m_pidx  = (m_owner + N - 1) % N;
            m_owner = -1;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        logic         ri;
        logic [N-1:0] rr;
        int           n_exp;

        init = 1'b1;
        req  = '0;

        // Reset with all requests high.
        add(1, 4'b1111, 4'b0000, 0, 4'b1000, 0);
        add(1, 4'b1111, 4'b0000, 0, 4'b1000, 0);
        // Burst limit: 8 cycles of grant, forced release, then next requester.
        for (int k = 0; k < MAXB; k++) add(0, 4'b0011, 4'b0010, 1, 4'b1000, 0);
        add(0, 4'b0011, 4'b0000, 0, 4'b0001, 1);
        add(0, 4'b0011, 4'b0001, 1, 4'b0001, 0);
        // Reset from a busy state.
        add(1, 4'b1111, 4'b0000, 0, 4'b1000, 0);
        // Round-robin fairness: owner drops request for one edge after its grant.
        add(0, 4'b1111, 4'b1000, 1, 4'b1000, 0);
        add(0, 4'b0111, 4'b0000, 0, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 1, 4'b0100, 0);
        add(0, 4'b1011, 4'b0000, 0, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 1, 4'b0010, 0);
        add(0, 4'b1101, 4'b0000, 0, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 1, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 1, 4'b1000, 0);
        // Voluntary release after 3 cycles, then idle hold.
        add(1, 4'b0000, 4'b0000, 0, 4'b1000, 0);
        for (int k = 0; k < 3; k++) add(0, 4'b0100, 4'b0100, 1, 4'b1000, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0010, 0);
        // Owner drops request exactly at the limit: no expire.
        add(1, 4'b0000, 4'b0000, 0, 4'b1000, 0);
        for (int k = 0; k < MAXB; k++) add(0, 4'b0001, 4'b0001, 1, 4'b1000, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b1000, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].i, vecs[k].r);
            check("table", k, vecs[k].g, vecs[k].b, vecs[k].p, vecs[k].e);
        end

        // Mid-grant reset with an ignored non-owner pulse.
        drive(1, 4'b0000);
        drive(0, 4'b0010);
        check("midgrant_own", 0, 4'b0010, 1, 4'b1000, 0);
        drive(0, 4'b1010);
        check("midgrant_pulse", 1, 4'b0010, 1, 4'b1000, 0);
        drive(1, 4'b0010);
        check("midgrant_init", 2, 4'b0000, 0, 4'b1000, 0);
        drive(0, 4'b1010);
        check("midgrant_rearb", 3, 4'b1000, 1, 4'b1000, 0);

        // Randomized run against the reference model.
        drive(1, 4'b0000);
        model_step(1, 4'b0000);
        rr = '0;
        n_exp = 0;
        for (int k = 0; k < 3000; k++) begin
            ri = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 4) == 0) rr = N'($urandom);
            model_step(ri, rr);
            drive(ri, rr);
            if (m_exp) n_exp++;
            check("random", k, onehot(m_owner), (m_owner >= 0), onehot(m_pidx), m_exp);
        end
        total++;
        if (n_exp == 0) begin
            bad++;
            $display("FAIL random_expire_seen: got %0d forced releases, want at least 1", n_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
